issue_scoreboard: RTL and testbench



---
 rtl/issue_scoreboard.sv | 157 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - dual-issue int/fp register scoreboard producing per-slot decode stalls
module issue_scoreboard #(
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             inst0_valid_pre_i,
  input  logic             inst0_rs1_valid_i,
  input  logic             inst0_rs2_valid_i,
  input  logic             inst0_rs3_valid_i,
  input  logic [4:0]       inst0_rs1_i,
  input  logic [4:0]       inst0_rs2_i,
  input  logic [4:0]       inst0_rs3_i,
  input  logic             inst0_rs1_fp_i,
  input  logic             inst0_rs2_fp_i,
  input  logic             inst0_rs3_fp_i,
  input  logic [1:0]       inst0_rd_type_i,
  input  logic [4:0]       inst0_rd_i,
  input  logic             inst1_valid_pre_i,
  input  logic             inst1_rs1_valid_i,
  input  logic             inst1_rs2_valid_i,
  input  logic             inst1_rs3_valid_i,
  input  logic [4:0]       inst1_rs1_i,
  input  logic [4:0]       inst1_rs2_i,
  input  logic [4:0]       inst1_rs3_i,
  input  logic             inst1_rs1_fp_i,
  input  logic             inst1_rs2_fp_i,
  input  logic             inst1_rs3_fp_i,
  input  logic [1:0]       inst1_rd_type_i,
  input  logic [4:0]       inst1_rd_i,
  input  logic             wb0_valid_i,
  input  logic [1:0]       wb0_rd_type_i,
  input  logic [4:0]       wb0_rd_i,
  input  logic             wb1_valid_i,
  input  logic [1:0]       wb1_rd_type_i,
  input  logic [4:0]       wb1_rd_i,
  output logic             stall_decoder_inst0_o,
  output logic             stall_decoder_inst1_o,
  output logic [31:0]      int_busy_o,
  output logic [31:0]      fp_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [1:0] RD_INT = 2'b01;
  localparam logic [1:0] RD_FP  = 2'b10;

  logic [31:1]      int_busy_q, int_busy_d;
  logic [31:0]      fp_busy_q, fp_busy_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [31:0] wbclr_int, wbclr_fp, eff_int, eff_fp, set_int, set_fp;
  logic [NUM_WB-1:0] wb_v;
  logic [1:0]        wb_t  [NUM_WB];
  logic [4:0]        wb_rd [NUM_WB];
  logic haz0, haz1, dep10, stall0, stall1, issue0, issue1;

  function automatic logic [31:0] onehot(input logic en, input logic [4:0] a);
    return en ? (32'd1 << a) : 32'd0;
  endfunction

  function automatic logic src_hit(input logic v, input logic fp, input logic [4:0] a,
                                   input logic [31:0] ei, input logic [31:0] ef);
    return v & (fp ? ef[a] : ei[a]);
  endfunction

  function automatic logic dst_hit(input logic [1:0] t, input logic [4:0] a,
                                   input logic [31:0] ei, input logic [31:0] ef);
    return ((t == RD_INT) && (a != 5'd0) && ei[a]) || ((t == RD_FP) && ef[a]);
  endfunction

  // Does an operand of slot 1 (source or destination) name slot 0's destination in the same file?
  function automatic logic dep_on(input logic [1:0] t0, input logic [4:0] rd0,
                                  input logic v, input logic fp, input logic [4:0] a);
    return v && (a == rd0) &&
           (((t0 == RD_INT) && (rd0 != 5'd0) && !fp) || ((t0 == RD_FP) && fp));
  endfunction

  assign wb_v  = {wb1_valid_i, wb0_valid_i};
  assign wb_t  = '{wb0_rd_type_i, wb1_rd_type_i};
  assign wb_rd = '{wb0_rd_i, wb1_rd_i};

  always_comb begin
    wbclr_int = 32'd0;
    wbclr_fp  = 32'd0;
    for (int k = 0; k < NUM_WB; k++) begin
      wbclr_int = wbclr_int | onehot(wb_v[k] && (wb_t[k] == RD_INT), wb_rd[k]);
      wbclr_fp  = wbclr_fp  | onehot(wb_v[k] && (wb_t[k] == RD_FP),  wb_rd[k]);
    end
  end

  // Writeback bypass: a register retiring this cycle no longer blocks a consumer.
  assign eff_int = {int_busy_q, 1'b0} & ~wbclr_int;
  assign eff_fp  = fp_busy_q & ~wbclr_fp;

  assign haz0 = src_hit(inst0_rs1_valid_i, inst0_rs1_fp_i, inst0_rs1_i, eff_int, eff_fp) |
                src_hit(inst0_rs2_valid_i, inst0_rs2_fp_i, inst0_rs2_i, eff_int, eff_fp) |
                src_hit(inst0_rs3_valid_i, inst0_rs3_fp_i, inst0_rs3_i, eff_int, eff_fp) |
                dst_hit(inst0_rd_type_i, inst0_rd_i, eff_int, eff_fp);

  assign haz1 = src_hit(inst1_rs1_valid_i, inst1_rs1_fp_i, inst1_rs1_i, eff_int, eff_fp) |
                src_hit(inst1_rs2_valid_i, inst1_rs2_fp_i, inst1_rs2_i, eff_int, eff_fp) |
                src_hit(inst1_rs3_valid_i, inst1_rs3_fp_i, inst1_rs3_i, eff_int, eff_fp) |
                dst_hit(inst1_rd_type_i, inst1_rd_i, eff_int, eff_fp);

  assign dep10 =
    dep_on(inst0_rd_type_i, inst0_rd_i, inst1_rs1_valid_i, inst1_rs1_fp_i, inst1_rs1_i) |
    dep_on(inst0_rd_type_i, inst0_rd_i, inst1_rs2_valid_i, inst1_rs2_fp_i, inst1_rs2_i) |
    dep_on(inst0_rd_type_i, inst0_rd_i, inst1_rs3_valid_i, inst1_rs3_fp_i, inst1_rs3_i) |
    dep_on(inst0_rd_type_i, inst0_rd_i, inst1_rd_type_i == RD_INT, 1'b0, inst1_rd_i) |
    dep_on(inst0_rd_type_i, inst0_rd_i, inst1_rd_type_i == RD_FP,  1'b1, inst1_rd_i);

  assign stall0 = inst0_valid_pre_i & haz0;
  assign stall1 = inst1_valid_pre_i & (haz1 | stall0 | (inst0_valid_pre_i & dep10));
  assign issue0 = inst0_valid_pre_i & ~stall0 & ~flush_i;
  assign issue1 = inst1_valid_pre_i & ~stall1 & ~flush_i;

  assign set_int = onehot(issue0 && (inst0_rd_type_i == RD_INT), inst0_rd_i) |
                   onehot(issue1 && (inst1_rd_type_i == RD_INT), inst1_rd_i);
  assign set_fp  = onehot(issue0 && (inst0_rd_type_i == RD_FP), inst0_rd_i) |
                   onehot(issue1 && (inst1_rd_type_i == RD_FP), inst1_rd_i);

  always_comb begin
    int_busy_d     = int_busy_q;
    fp_busy_d      = fp_busy_q;
    stall_cycles_d = stall_cycles_q;
    if (flush_i) begin
      int_busy_d = '0;
      fp_busy_d  = '0;
    end else begin
      int_busy_d = (int_busy_q & ~wbclr_int[31:1]) | set_int[31:1];
      fp_busy_d  = (fp_busy_q & ~wbclr_fp) | set_fp;
    end
    if ((stall0 | stall1) && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_busy_q     <= '0;
      fp_busy_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      int_busy_q     <= int_busy_d;
      fp_busy_q      <= fp_busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_decoder_inst0_o = stall0;
  assign stall_decoder_inst1_o = stall1;
  assign int_busy_o            = {int_busy_q, 1'b0};
  assign fp_busy_o             = fp_busy_q;
  assign stall_cycles_o        = stall_cycles_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed vector bench for issue_scoreboard
module tb_issue_scoreboard;

  typedef struct packed {
    logic       v;
    logic [2:0] sv;
    logic [2:0] sfp;
    logic [4:0] rs1, rs2, rs3;
    logic [1:0] rdt;
    logic [4:0] rd;
  } slot_t;

  typedef struct packed {
    logic       v;
    logic [1:0] t;
    logic [4:0] rd;
  } wb_t;

  typedef struct {
    string       name;
    logic        flush;
    slot_t       s0, s1;
    wb_t         w0, w1;
    logic        e_st0, e_st1;
    logic [31:0] e_int, e_fp;
    int          e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush;
  slot_t s0, s1;
  wb_t w0, w1;
  logic st0, st1, st0_s, st1_s;
  logic [31:0] ib, fb, ib_s, fb_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .inst0_valid_pre_i(s0.v),
    .inst0_rs1_valid_i(s0.sv[0]), .inst0_rs2_valid_i(s0.sv[1]), .inst0_rs3_valid_i(s0.sv[2]),
    .inst0_rs1_i(s0.rs1), .inst0_rs2_i(s0.rs2), .inst0_rs3_i(s0.rs3),
    .inst0_rs1_fp_i(s0.sfp[0]), .inst0_rs2_fp_i(s0.sfp[1]), .inst0_rs3_fp_i(s0.sfp[2]),
    .inst0_rd_type_i(s0.rdt), .inst0_rd_i(s0.rd),
    .inst1_valid_pre_i(s1.v),
    .inst1_rs1_valid_i(s1.sv[0]), .inst1_rs2_valid_i(s1.sv[1]), .inst1_rs3_valid_i(s1.sv[2]),
    .inst1_rs1_i(s1.rs1), .inst1_rs2_i(s1.rs2), .inst1_rs3_i(s1.rs3),
    .inst1_rs1_fp_i(s1.sfp[0]), .inst1_rs2_fp_i(s1.sfp[1]), .inst1_rs3_fp_i(s1.sfp[2]),
    .inst1_rd_type_i(s1.rdt), .inst1_rd_i(s1.rd),
    .wb0_valid_i(w0.v), .wb0_rd_type_i(w0.t), .wb0_rd_i(w0.rd),
    .wb1_valid_i(w1.v), .wb1_rd_type_i(w1.t), .wb1_rd_i(w1.rd),
    .stall_decoder_inst0_o(st0), .stall_decoder_inst1_o(st1),
    .int_busy_o(ib), .fp_busy_o(fb), .stall_cycles_o(cnt)
  );

  issue_scoreboard #(.NUM_WB(2), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .inst0_valid_pre_i(s0.v),
    .inst0_rs1_valid_i(s0.sv[0]), .inst0_rs2_valid_i(s0.sv[1]), .inst0_rs3_valid_i(s0.sv[2]),
    .inst0_rs1_i(s0.rs1), .inst0_rs2_i(s0.rs2), .inst0_rs3_i(s0.rs3),
    .inst0_rs1_fp_i(s0.sfp[0]), .inst0_rs2_fp_i(s0.sfp[1]), .inst0_rs3_fp_i(s0.sfp[2]),
    .inst0_rd_type_i(s0.rdt), .inst0_rd_i(s0.rd),
    .inst1_valid_pre_i(s1.v),
    .inst1_rs1_valid_i(s1.sv[0]), .inst1_rs2_valid_i(s1.sv[1]), .inst1_rs3_valid_i(s1.sv[2]),
    .inst1_rs1_i(s1.rs1), .inst1_rs2_i(s1.rs2), .inst1_rs3_i(s1.rs3),
    .inst1_rs1_fp_i(s1.sfp[0]), .inst1_rs2_fp_i(s1.sfp[1]), .inst1_rs3_fp_i(s1.sfp[2]),
    .inst1_rd_type_i(s1.rdt), .inst1_rd_i(s1.rd),
    .wb0_valid_i(w0.v), .wb0_rd_type_i(w0.t), .wb0_rd_i(w0.rd),
    .wb1_valid_i(w1.v), .wb1_rd_type_i(w1.t), .wb1_rd_i(w1.rd),
    .stall_decoder_inst0_o(st0_s), .stall_decoder_inst1_o(st1_s),
    .int_busy_o(ib_s), .fp_busy_o(fb_s), .stall_cycles_o(cnt_s)
  );

  // Slot reading one register through rs1 (rs1_on=0 means no source) with an optional destination.
  function automatic slot_t sl(input logic rs1_on, input logic rs1_fp, input logic [4:0] rs1,
                               input logic [1:0] rdt, input logic [4:0] rd);
    slot_t s = '0;
    s.v = 1'b1; s.sv[0] = rs1_on; s.sfp[0] = rs1_fp; s.rs1 = rs1; s.rdt = rdt; s.rd = rd;
    return s;
  endfunction

  function automatic wb_t wb(input logic [1:0] t, input logic [4:0] rd);
    wb_t w;
    w.v = 1'b1; w.t = t; w.rd = rd;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; s0 = '0; s1 = '0; w0 = '0; w1 = '0;
  endtask

  vec_t vecs[$];
  vec_t v;
  slot_t t;

  initial begin
    idle();
    // name, flush, s0, s1, w0, w1, stall0, stall1, int_busy_after, fp_busy_after, cnt_after
    vecs.push_back('{"issue_x5",    0, sl(1,0,1,2'b01,5), '0, '0, '0, 0,0, 32'h20, 0, 0});
    vecs.push_back('{"raw_x5",      0, sl(1,0,5,2'b00,0), '0, '0, '0, 1,0, 32'h20, 0, 1});
    vecs.push_back('{"raw_x5_b",    0, sl(1,0,5,2'b00,0), '0, '0, '0, 1,0, 32'h20, 0, 2});
    vecs.push_back('{"wb_bypass",   0, sl(1,0,5,2'b00,0), '0, wb(2'b01,5), '0, 0,0, 0, 0, 2});
    vecs.push_back('{"pair_dep",    0, sl(0,0,0,2'b01,7), sl(1,0,7,2'b00,0), '0, '0, 0,1, 32'h80, 0, 3});
    vecs.push_back('{"s1_busy7",    0, '0, sl(1,0,7,2'b00,0), '0, '0, 0,1, 32'h80, 0, 4});
    vecs.push_back('{"wb1_x7",      0, '0, sl(1,0,7,2'b00,0), '0, wb(2'b01,7), 0,0, 0, 0, 4});
    vecs.push_back('{"fp_vs_int",   0, sl(0,0,0,2'b10,3), sl(1,0,3,2'b00,0), '0, '0, 0,0, 0, 32'h8, 4});
    t = '0; t.v = 1; t.sv = 3'b100; t.sfp = 3'b100; t.rs3 = 5'd3;
    vecs.push_back('{"fp_raw_rs3",  0, t, sl(0,0,0,2'b00,0), '0, '0, 1,1, 0, 32'h8, 5});
    vecs.push_back('{"waw_f3",      0, sl(0,0,0,2'b10,3), '0, '0, '0, 1,0, 0, 32'h8, 6});
    vecs.push_back('{"set_x2_f1",   0, sl(0,0,0,2'b01,2), sl(0,0,0,2'b10,1), wb(2'b10,3), '0, 0,0, 32'h4, 32'h2, 6});
    vecs.push_back('{"set_x9",      0, sl(0,0,0,2'b01,9), '0, '0, '0, 0,0, 32'h204, 32'h2, 6});
    vecs.push_back('{"flush",       1, sl(0,0,0,2'b01,4), '0, '0, wb(2'b01,9), 0,0, 0, 0, 6});
    vecs.push_back('{"write_x0",    0, sl(0,0,0,2'b01,0), sl(1,0,0,2'b00,0), '0, '0, 0,0, 0, 0, 6});
    vecs.push_back('{"set_wins",    0, sl(0,0,0,2'b01,6), '0, wb(2'b01,6), '0, 0,0, 32'h40, 0, 6});
    vecs.push_back('{"waw_flush",   1, sl(0,0,0,2'b01,6), '0, '0, '0, 1,0, 0, 0, 7});
    vecs.push_back('{"rsv_type",    0, sl(0,0,0,2'b11,5), sl(1,0,5,2'b00,0), '0, '0, 0,0, 0, 0, 7});
    vecs.push_back('{"set_f10",     0, sl(0,0,0,2'b10,10), '0, '0, '0, 0,0, 0, 32'h400, 7});
    t = '0; t.v = 1; t.sv = 3'b010; t.sfp = 3'b010; t.rs2 = 5'd10;
    vecs.push_back('{"dual_wb",     0, t, '0, wb(2'b10,10), wb(2'b10,10), 0,0, 0, 0, 7});
    vecs.push_back('{"waw_s1_dep",  0, sl(0,0,0,2'b10,4), sl(0,0,0,2'b10,4), '0, '0, 0,1, 0, 32'h10, 8});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_int_busy", ib, 0);
    chk("reset_fp_busy", fb, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_stall0", st0, 0);
    chk("reset_stall1", st1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      flush = v.flush; s0 = v.s0; s1 = v.s1; w0 = v.w0; w1 = v.w1;
      #1;
      chk({v.name, "_stall0"}, st0, v.e_st0);
      chk({v.name, "_stall1"}, st1, v.e_st1);
      @(posedge clk); #1;
      chk({v.name, "_int_busy"}, ib, v.e_int);
      chk({v.name, "_fp_busy"}, fb, v.e_fp);
      chk({v.name, "_cnt"}, cnt, v.e_cnt);
      chk({v.name, "_cnt4"}, cnt_s, (v.e_cnt > 15) ? 15 : v.e_cnt);
    end

    // Long stall on f4 drives the 4-bit counter into saturation.
    idle();
    s0 = sl(1, 1, 4, 2'b00, 0);
    for (int c = 1; c <= 20; c++) begin
      #1;
      chk("sat_stall0", st0, 1);
      @(posedge clk); #1;
      if (c == 7) chk("cnt4_reaches_max", cnt_s, 4'hF);
    end
    chk("cnt32_after_sat", cnt, 28);
    chk("cnt4_saturated", cnt_s, 4'hF);
    chk("fp_busy_held", fb, 32'h10);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fp", fb, 0);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_cnt4", cnt_s, 0);
    idle();
    #1;
    chk("async_rst_stall0", st0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = wb(2'b10, 4);
    @(posedge clk); #1;
    chk("wb_after_reset", fb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
